// File: rtl/line_port_pkg.sv
// Shared definitions for the line_port cache-line transfer block:
// FSM state encoding, bus widths and line-length helper.
package line_port_pkg;

    localparam int BADDR_W = 24;    // cache-side byte address width
    localparam int HADDR_W = 23;    // SDRAM halfword address width
    localparam int DATA_W  = 16;    // word width on both sides

    localparam int DEFAULT_OFFSETWIDTH = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        WR_ISSUE = 2'd2
    } state_e;

    // Number of 16-bit words in one cache line of 2**offsetwidth bytes.
    function automatic int line_words(input int offsetwidth);
        return 1 << (offsetwidth - 1);
    endfunction

    localparam int LW = line_words(DEFAULT_OFFSETWIDTH);

endpackage

// File: rtl/line_port_if.sv
// Bus bundles around line_port: the cache-facing port (cache is master)
// and the SDRAM command/return port (line_port is master).
interface line_cache_if;
    import line_port_pkg::*;

    logic                readreq;
    logic [BADDR_W-1:0]  rd_addr;
    logic                writereq;
    logic [BADDR_W-1:0]  wr_addr;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   data_to_ram;
    logic [DATA_W-1:0]   data_from_ram;
    logic                readready;
    logic                writeready;
    logic                busy;

    modport master (
        output readreq, rd_addr, writereq, wr_addr, read, write, data_to_ram,
        input  data_from_ram, readready, writeready, busy
    );

    modport slave (
        input  readreq, rd_addr, writereq, wr_addr, read, write, data_to_ram,
        output data_from_ram, readready, writeready, busy
    );
endinterface

interface line_mem_if;
    import line_port_pkg::*;

    logic                mem_cmd_valid;
    logic                mem_cmd_ready;
    logic                mem_cmd_we;
    logic [HADDR_W-1:0]  mem_cmd_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_rdata_valid;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
        input  mem_cmd_ready, mem_rdata_valid, mem_rdata
    );

    modport slave (
        input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
        output mem_cmd_ready, mem_rdata_valid, mem_rdata
    );
endinterface

// File: rtl/line_fifo.sv
// Synchronous FIFO with occupancy count. Head word is visible
// combinationally; simultaneous push and pop are both honoured, including
// push while full when a pop happens in the same cycle.
module line_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage array: written on push, contents need no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/line_port.sv
// line_port: moves whole cache lines between a cache and an SDRAM
// controller. Fills land in a read FIFO, evictions drain from a write FIFO.
// Optional build macro LINE_PORT_CRITICAL_WORD_FIRST_EN: fills start at the
// requested word and wrap around the line; otherwise fills start at word 0.
module line_port
    import line_port_pkg::*;
#(
    parameter int OFFSETWIDTH = 5,
    parameter int FIFODEPTH   = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    line_cache_if.slave  cache,
    line_mem_if.master   mem
);
    localparam int LINE_WORDS = line_words(OFFSETWIDTH);
    localparam int OW         = OFFSETWIDTH - 1;          // word-offset bits
    localparam int LINE_W     = BADDR_W - OFFSETWIDTH;    // line-number bits
    localparam int CW         = $clog2(FIFODEPTH) + 1;    // FIFO count width

    state_e              state_q;
    logic                rd_pend_q, wr_pend_q;
    logic [LINE_W-1:0]   rd_line_q, wr_line_q;
    logic [OW-1:0]       rd_start_q;
    logic [OW-1:0]       off_q;
    logic [OW:0]         iss_q;
    logic                cmd_valid_q, cmd_we_q;
    logic [HADDR_W-1:0]  cmd_addr_q;
    logic [CW-1:0]       out_q;
    logic                init_q;

    logic [DATA_W-1:0]   r_dout, w_dout;
    logic [CW-1:0]       r_count, w_count;
    logic                r_full, r_empty, w_full, w_empty;
    logic                r_push, r_pop, w_push, w_pop;

    logic                hs, slot_free, more, credit_ok, w_avail;
    logic                issue_rd, issue_wr, ret;
    logic [OW-1:0]       req_start;

`ifdef LINE_PORT_CRITICAL_WORD_FIRST_EN
    assign req_start = cache.rd_addr[OFFSETWIDTH-1:1];
`else
    assign req_start = '0;
`endif

    assign hs        = cmd_valid_q & mem.mem_cmd_ready;
    assign slot_free = ~cmd_valid_q | hs;
    assign more      = (iss_q < (OW+1)'(LINE_WORDS));
    // Every raised read command holds a FIFO slot until its word is popped,
    // so returns can always be pushed without back-pressure.
    assign credit_ok = (({1'b0, r_count} + {1'b0, out_q}) < (CW+1)'(FIFODEPTH));
    // The next write needs a word behind the one leaving on this handshake.
    assign w_avail   = hs ? (w_count > CW'(1)) : ~w_empty;
    assign issue_rd  = (state_q == RD_ISSUE) & slot_free & more & credit_ok;
    assign issue_wr  = (state_q == WR_ISSUE) & slot_free & more & w_avail;
    // Returns with nothing outstanding (e.g. stragglers after reset) are dropped.
    assign ret       = mem.mem_rdata_valid & (out_q != '0);

    assign r_push = ret & (~r_full | r_pop);
    assign r_pop  = cache.read & ~r_empty;
    assign w_push = cache.write & ~w_full;
    assign w_pop  = hs & cmd_we_q;

    line_fifo #(.WIDTH(DATA_W), .DEPTH(FIFODEPTH)) u_rd_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (r_push),
        .din     (mem.mem_rdata),
        .pop     (r_pop),
        .dout    (r_dout),
        .count   (r_count),
        .full    (r_full),
        .empty   (r_empty)
    );

    line_fifo #(.WIDTH(DATA_W), .DEPTH(FIFODEPTH)) u_wr_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .din     (cache.data_to_ram),
        .pop     (w_pop),
        .dout    (w_dout),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Request flags, burst sequencing and the registered command outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rd_pend_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_line_q   <= '0;
            wr_line_q   <= '0;
            rd_start_q  <= '0;
            off_q       <= '0;
            iss_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
        end else begin
            if (cache.readreq && !rd_pend_q) begin
                rd_pend_q  <= 1'b1;
                rd_line_q  <= cache.rd_addr[BADDR_W-1:OFFSETWIDTH];
                rd_start_q <= req_start;
            end
            if (cache.writereq && !wr_pend_q) begin
                wr_pend_q <= 1'b1;
                wr_line_q <= cache.wr_addr[BADDR_W-1:OFFSETWIDTH];
            end
            case (state_q)
                IDLE: begin
                    iss_q <= '0;
                    if (rd_pend_q) begin
                        state_q <= RD_ISSUE;
                        off_q   <= rd_start_q;
                    end else if (wr_pend_q) begin
                        state_q <= WR_ISSUE;
                        off_q   <= '0;
                    end
                end
                RD_ISSUE: begin
                    if (issue_rd) begin
                        cmd_valid_q <= 1'b1;
                        cmd_we_q    <= 1'b0;
                        cmd_addr_q  <= {rd_line_q, off_q};
                        off_q       <= off_q + OW'(1);
                        iss_q       <= iss_q + (OW+1)'(1);
                    end else if (hs) begin
                        cmd_valid_q <= 1'b0;
                        if (!more) begin
                            state_q   <= IDLE;
                            rd_pend_q <= 1'b0;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (issue_wr) begin
                        cmd_valid_q <= 1'b1;
                        cmd_we_q    <= 1'b1;
                        cmd_addr_q  <= {wr_line_q, off_q};
                        off_q       <= off_q + OW'(1);
                        iss_q       <= iss_q + (OW+1)'(1);
                    end else if (hs) begin
                        cmd_valid_q <= 1'b0;
                        if (!more) begin
                            state_q   <= IDLE;
                            wr_pend_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reads in flight: counted when raised, released when the word returns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_q + CW'(issue_rd) - CW'(ret);
        end
    end

    // Keeps writeready low through reset and for the first cycle after it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    assign cache.data_from_ram = r_empty ? '0 : r_dout;
    assign cache.readready     = ~r_empty;
    assign cache.writeready    = init_q & ~w_full;
    assign cache.busy          = rd_pend_q | wr_pend_q | (state_q != IDLE) | (out_q != '0);

    assign mem.mem_cmd_valid = cmd_valid_q;
    assign mem.mem_cmd_we    = cmd_we_q;
    assign mem.mem_cmd_addr  = cmd_addr_q;
    assign mem.mem_wdata     = (cmd_valid_q & cmd_we_q) ? w_dout : '0;
endmodule

// File: tb/tb_line_port.sv
// Directed bench for line_port: fills, CWF ordering, evictions with a
// stalling controller, read/write priority, FIFO credit limit and reset.
module tb_line_port;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    line_cache_if cif ();
    line_mem_if   mif ();

    line_port #(.OFFSETWIDTH(5), .FIFODEPTH(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .cache   (cif),
        .mem     (mif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Controller / cache model state
    int          ready_mode = 0;   // 0 always ready, 1 toggle, 2 never
    bit          ready_b;
    bit          auto_pop;
    bit          pipe_v0, pipe_v1;
    logic [15:0] pipe_d0, pipe_d1;
    bit          prev_v, prev_r, prev_we;
    logic [22:0] prev_addr;
    int          stab_err = 0;
    logic [22:0] cmd_addr_q [$];
    bit          cmd_we_q   [$];
    logic [15:0] cmd_wd_q   [$];
    logic [15:0] popped_q   [$];

    function automatic logic [15:0] rdf(input logic [22:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SDRAM controller with 2-cycle return latency and a popping cache.
    always @(negedge clock) begin
        mif.mem_rdata_valid = pipe_v1;
        mif.mem_rdata       = pipe_d1;
        pipe_v1 = pipe_v0;
        pipe_d1 = pipe_d0;
        pipe_v0 = 1'b0;
        case (ready_mode)
            1:       ready_b = ~ready_b;
            2:       ready_b = 1'b0;
            default: ready_b = 1'b1;
        endcase
        mif.mem_cmd_ready = ready_b;
        if (prev_v && !prev_r) begin
            if (mif.mem_cmd_valid !== 1'b1 || mif.mem_cmd_we !== prev_we ||
                mif.mem_cmd_addr !== prev_addr)
                stab_err++;
        end
        prev_v    = (mif.mem_cmd_valid === 1'b1);
        prev_r    = ready_b;
        prev_we   = mif.mem_cmd_we;
        prev_addr = mif.mem_cmd_addr;
        if (mif.mem_cmd_valid === 1'b1 && ready_b) begin
            cmd_addr_q.push_back(mif.mem_cmd_addr);
            cmd_we_q.push_back(mif.mem_cmd_we);
            cmd_wd_q.push_back(mif.mem_wdata);
            if (!mif.mem_cmd_we) begin
                pipe_v0 = 1'b1;
                pipe_d0 = rdf(mif.mem_cmd_addr);
            end
        end
        cif.read = auto_pop && (cif.readready === 1'b1);
        if (cif.read) popped_q.push_back(cif.data_from_ram);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        cmd_addr_q.delete();
        cmd_we_q.delete();
        cmd_wd_q.delete();
        popped_q.delete();
    endtask

    task automatic wait_cmds(input string tag, input int n, input int budget);
        int k = 0;
        while (cmd_addr_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, cmd_addr_q.size(), n);
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int k = 0;
        while (popped_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, popped_q.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (cif.busy !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        chk(tag, cif.busy, 0);
    endtask

    task automatic pulse_rd(input logic [23:0] a);
        cif.readreq = 1'b1;
        cif.rd_addr = a;
        step();
        cif.readreq = 1'b0;
    endtask

    task automatic pulse_wr(input logic [23:0] a);
        cif.writereq = 1'b1;
        cif.wr_addr  = a;
        step();
        cif.writereq = 1'b0;
    endtask

    task automatic push_words(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            chk("wr_ready_pre", cif.writeready, 1);
            cif.write       = 1'b1;
            cif.data_to_ram = base + 16'(i);
            step();
        end
        cif.write = 1'b0;
        chk("wr_full", cif.writeready, 0);
    endtask

    // Check a 16-word fill whose line base is 'base', starting at 'start'.
    task automatic check_fill(input string tag, input logic [22:0] base, input int start);
        logic [22:0] ea;
        for (int i = 0; i < 16; i++) begin
            ea = base + 23'((start + i) % 16);
            chk({tag, "_addr"}, cmd_addr_q[i], ea);
            chk({tag, "_we"}, cmd_we_q[i], 0);
            chk({tag, "_data"}, popped_q[i], rdf(ea));
        end
        $display("burst %s read base=%h start=%0d cmds=%0d", tag, base, start, cmd_addr_q.size());
    endtask

    int cwf_start;

    initial begin
`ifdef LINE_PORT_CRITICAL_WORD_FIRST_EN
        cwf_start = 5;
`else
        cwf_start = 0;
`endif
        reset_n          = 1'b0;
        cif.readreq      = 1'b0;
        cif.rd_addr      = '0;
        cif.writereq     = 1'b0;
        cif.wr_addr      = '0;
        cif.write        = 1'b0;
        cif.data_to_ram  = '0;
        auto_pop         = 1'b1;
        cycles(3);
        chk("rst_valid", mif.mem_cmd_valid, 0);
        chk("rst_busy", cif.busy, 0);
        chk("rst_rdy", cif.readready, 0);
        chk("rst_wrdy", cif.writeready, 0);
        chk("rst_dout", cif.data_from_ram, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        reset_n = 1'b1;
        step();
        chk("post_rst_wrdy", cif.writeready, 1);

        // Basic fill, offset 0
        clear_log();
        pulse_rd(24'h000040);
        wait_cmds("rd39_ncmd", 16, 300);
        wait_pops("rd39_npop", 16, 300);
        wait_idle("rd39_idle", 100);
        chk("rd39_total", cmd_addr_q.size(), 16);
        check_fill("rd39", 23'h20, 0);

        // Fill requested at word 5
        clear_log();
        pulse_rd(24'h00004A);
        wait_cmds("rd40_ncmd", 16, 300);
        wait_pops("rd40_npop", 16, 300);
        wait_idle("rd40_idle", 100);
        check_fill("rd40", 23'h20, cwf_start);

        // Eviction with a stalling controller
        clear_log();
        push_words(16'hA000);
        ready_mode = 1;
        pulse_wr(24'h001000);
        wait_cmds("wr41_ncmd", 16, 300);
        wait_idle("wr41_idle", 100);
        for (int i = 0; i < 16; i++) begin
            chk("wr41_addr", cmd_addr_q[i], 23'h800 + 23'(i));
            chk("wr41_we", cmd_we_q[i], 1);
            chk("wr41_data", cmd_wd_q[i], 16'hA000 + 16'(i));
        end
        chk("wr41_wrdy", cif.writeready, 1);
        $display("burst wr41 write base=800 cmds=%0d", cmd_addr_q.size());
        ready_mode = 0;

        // Simultaneous requests: read line goes first
        clear_log();
        push_words(16'hB000);
        cif.readreq  = 1'b1;
        cif.rd_addr  = 24'h000100;
        cif.writereq = 1'b1;
        cif.wr_addr  = 24'h002000;
        step();
        cif.readreq  = 1'b0;
        cif.writereq = 1'b0;
        wait_cmds("rw42_ncmd", 32, 400);
        chk("rw42_busy_last", cif.busy, 1);
        step();
        chk("rw42_busy_done", cif.busy, 0);
        for (int i = 0; i < 16; i++) begin
            chk("rw42_rd_we", cmd_we_q[i], 0);
            chk("rw42_rd_addr", cmd_addr_q[i], 23'h80 + 23'((cwf_start * 0 + i) % 16));
            chk("rw42_wr_we", cmd_we_q[16 + i], 1);
            chk("rw42_wr_addr", cmd_addr_q[16 + i], 23'h1000 + 23'(i));
            chk("rw42_wr_data", cmd_wd_q[16 + i], 16'hB000 + 16'(i));
        end
        $display("burst rw42 read+write cmds=%0d", cmd_addr_q.size());
        wait_idle("rw42_idle", 100);

        // Cache stops popping: second fill must wait for FIFO space
        clear_log();
        auto_pop = 1'b0;
        pulse_rd(24'h000200);
        wait_cmds("cr43_ncmd1", 16, 300);
        cycles(10);
        chk("cr43_rdy", cif.readready, 1);
        pulse_rd(24'h000240);
        cycles(40);
        chk("cr43_hold", cmd_addr_q.size(), 16);
        chk("cr43_busy", cif.busy, 1);
        auto_pop = 1'b1;
        wait_cmds("cr43_ncmd2", 32, 400);
        wait_pops("cr43_npop", 32, 400);
        wait_idle("cr43_idle", 100);
        for (int i = 0; i < 32; i++) begin
            logic [22:0] ea;
            ea = (i < 16) ? 23'h100 + 23'(i) : 23'h120 + 23'(i - 16);
            chk("cr43_addr", cmd_addr_q[i], ea);
            chk("cr43_data", popped_q[i], rdf(ea));
        end
        $display("burst cr43 two fills cmds=%0d pops=%0d", cmd_addr_q.size(), popped_q.size());

        // Reset in the middle of a fill
        clear_log();
        pulse_rd(24'h000300);
        wait_cmds("rs44_ncmd", 8, 300);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs44_valid", mif.mem_cmd_valid, 0);
        chk("rs44_busy", cif.busy, 0);
        chk("rs44_rdy", cif.readready, 0);
        chk("rs44_dout", cif.data_from_ram, 0);
        chk("rs44_wrdy", cif.writeready, 0);
        cycles(2);
        reset_n = 1'b1;
        cycles(5);
        chk("rs44_drop", cif.readready, 0);
        chk("rs44_idle", cif.busy, 0);
        clear_log();
        pulse_rd(24'h000400);
        wait_cmds("rs44_ncmd2", 16, 300);
        wait_pops("rs44_npop", 16, 300);
        wait_idle("rs44_idle2", 100);
        chk("rs44_total", cmd_addr_q.size(), 16);
        check_fill("rs44", 23'h200, 0);

        chk("cmd_hold", stab_err, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
